mult_div_unit: RTL

//   Iterative multiply/divide unit downstream of the ALU controller. Consumes the
//   4-bit ALU control code and executes MULT (4'b0110) and DIV (4'b0111) over

---
 rtl/mult_div_unit.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative multiply/divide unit writing HI/LO
//
// Shift-add multiplier and restoring divider sharing one 2*WIDTH accumulator.
// One bit is processed per cycle, so an operation takes WIDTH iterations.
// Optional build macro: SIGNED_MULDIV_EN (two's complement operands and an
// extra FIX cycle that applies the result signs).
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        request, sampled only while idle
//   control      4'b0110 = MULT, 4'b0111 = DIV, anything else ignored
//   a, b         multiplicand/dividend, multiplier/divisor
//   busy         operation in progress (pipeline stall request)
//   done         one-cycle pulse; hi/lo updated on the same edge
//   div_by_zero  set with done when a DIV had b == 0; cleared on next accept
//   hi, lo       MULT: product upper/lower; DIV: remainder/quotient
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int         CW       = $clog2(WIDTH) + 1;
    localparam logic [3:0] CTL_MULT = 4'b0110;
    localparam logic [3:0] CTL_DIV  = 4'b0111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opb_q, opb_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 dz_q, dz_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_diff;

`ifdef SIGNED_MULDIV_EN
    logic                 is_div_q, is_div_d;
    logic                 neg_hi_q, neg_hi_d;
    logic                 neg_lo_q, neg_lo_d;
    logic [2*WIDTH-1:0]   prod_fix;

    // Work on magnitudes; the signs are reapplied in the FIX cycle.
    assign a_mag    = a[WIDTH-1] ? -a : a;
    assign b_mag    = b[WIDTH-1] ? -b : b;
    assign prod_fix = neg_lo_q ? -acc_q : acc_q;
`else
    assign a_mag = a;
    assign b_mag = b;
`endif

    // Multiply step: conditionally add multiplicand to the upper half, keep
    // the carry, shift the whole accumulator right by one.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    // Divide step: partial remainder shifted left with the next dividend bit.
    assign div_diff = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opb_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
`ifdef SIGNED_MULDIV_EN
        is_div_d = is_div_q;
        neg_hi_d = neg_hi_q;
        neg_lo_d = neg_lo_q;
`endif
        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start && control == CTL_MULT) begin
                    state_d = S_MUL;
                    cnt_d   = '0;
                    acc_d   = {{WIDTH{1'b0}}, b_mag};
                    opb_d   = a_mag;
                    dz_d    = 1'b0;
`ifdef SIGNED_MULDIV_EN
                    is_div_d = 1'b0;
                    neg_hi_d = 1'b0;
                    neg_lo_d = a[WIDTH-1] ^ b[WIDTH-1];
`endif
                end else if (start && control == CTL_DIV) begin
                    if (b == '0) begin
                        // Divide by zero completes immediately, never busy.
                        hi_d   = a;
                        lo_d   = '1;
                        done_d = 1'b1;
                        dz_d   = 1'b1;
                    end else begin
                        state_d = S_DIV;
                        cnt_d   = '0;
                        acc_d   = {{WIDTH{1'b0}}, a_mag};
                        opb_d   = b_mag;
                        dz_d    = 1'b0;
`ifdef SIGNED_MULDIV_EN
                        is_div_d = 1'b1;
                        neg_hi_d = a[WIDTH-1];
                        neg_lo_d = a[WIDTH-1] ^ b[WIDTH-1];
`endif
                    end
                end
            end
            S_MUL, S_DIV: begin
                if (cnt_q == CW'(WIDTH)) begin
`ifdef SIGNED_MULDIV_EN
                    state_d = S_FIX;
                    busy_d  = 1'b1;
`else
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    hi_d    = acc_q[2*WIDTH-1:WIDTH];
                    lo_d    = acc_q[WIDTH-1:0];
`endif
                end else begin
                    busy_d = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    if (state_q == S_MUL) begin
                        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                    end else if (!div_diff[WIDTH]) begin
                        acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
                    end
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
`ifdef SIGNED_MULDIV_EN
                if (is_div_q) begin
                    hi_d = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                    lo_d = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opb_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
`ifdef SIGNED_MULDIV_EN
            is_div_q <= 1'b0;
            neg_hi_q <= 1'b0;
            neg_lo_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
`ifdef SIGNED_MULDIV_EN
            is_div_q <= is_div_d;
            neg_hi_q <= neg_hi_d;
            neg_lo_q <= neg_lo_d;
`endif
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule
